// File: rtl/uart_pkg.sv
// Shared packet layout, timing constants, parity helper and FSM encodings
// for the host-side register-file UART.
package uart_pkg;
  localparam int OVERSAMPLE     = 16;
  localparam int PKT_W          = 18;
  localparam int ADDR_LSB       = 9;
  localparam int DATA_LSB       = 1;
  localparam int WRB_BIT        = 0;
  localparam int PAR_BIT        = 17;
  localparam int FRAME_BITS     = PKT_W + 2;
  localparam int TIMEOUT_CYCLES = 1024;

  typedef struct packed {
    logic       par;
    logic [7:0] addr;
    logic [7:0] data;
    logic       wrb;
  } pkt_t;

  typedef enum logic [1:0] {IDLE, TX, WAIT_RSP, DONE} state_t;
  typedef enum logic [1:0] {RX_HUNT, RX_START, RX_DATA, RX_STOP} rx_state_t;

  function automatic logic pkt_parity(input logic [PKT_W-2:0] body);
    return ~^body;
  endfunction
endpackage

// File: rtl/uart_host_if.sv
// Request/response handshake between the harness and the UART host.
interface uart_host_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_write;
  logic [7:0] rsp_rdata;
  logic       rsp_parity_err;
  logic       rsp_addr_err;
  logic       rsp_timeout;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_write, rsp_rdata,
           rsp_parity_err, rsp_addr_err, rsp_timeout
  );
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_write, rsp_rdata,
           rsp_parity_err, rsp_addr_err, rsp_timeout
  );
endinterface

// File: rtl/uart_host_rx.sv
// Reply receiver: 2-flop synchronizer, mid-bit confirmed start detect,
// 16x sampling of 18 LSB-first bits plus stop. Held in hunt while en is low.
module uart_host_rx
  import uart_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             piso,
  output logic             start_det,
  output logic             done,
  output logic             stop_err,
  output logic [PKT_W-1:0] data
);
  localparam logic [3:0] MID  = 4'(OVERSAMPLE/2 - 1);
  localparam logic [3:0] LAST = 4'(OVERSAMPLE - 1);

  logic [1:0] sync;
  logic       s, s_d;
  rx_state_t  st;
  logic [3:0] cnt;
  logic [4:0] nbit;

  assign s         = sync[1];
  assign start_det = en && st == RX_HUNT && s_d && !s;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync <= 2'b11;
      s_d  <= 1'b1;
    end else begin
      sync <= {sync[0], piso};
      s_d  <= s;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st       <= RX_HUNT;
      cnt      <= '0;
      nbit     <= '0;
      done     <= 1'b0;
      stop_err <= 1'b0;
      data     <= '0;
    end else if (!en) begin
      st   <= RX_HUNT;
      cnt  <= '0;
      nbit <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (st)
        RX_HUNT: if (start_det) begin
          st  <= RX_START;
          cnt <= '0;
        end
        // a line that is high again at mid start-bit was only a glitch
        RX_START: if (cnt == MID) begin
          cnt  <= '0;
          nbit <= '0;
          st   <= s ? RX_HUNT : RX_DATA;
        end else cnt <= cnt + 4'd1;
        RX_DATA: if (cnt == LAST) begin
          cnt  <= '0;
          data <= {s, data[PKT_W-1:1]};
          nbit <= nbit + 5'd1;
          if (nbit == 5'(PKT_W - 1)) st <= RX_STOP;
        end else cnt <= cnt + 4'd1;
        RX_STOP: if (cnt == LAST) begin
          cnt      <= '0;
          done     <= 1'b1;
          stop_err <= !s;
          st       <= RX_HUNT;
        end else cnt <= cnt + 4'd1;
        default: st <= RX_HUNT;
      endcase
    end
  end
endmodule

// File: rtl/uart_host.sv
// Host initiator: serialises one request packet on posi and, for reads,
// collects the reply on piso. Optional read timeout under UART_HOST_TIMEOUT_EN.
module uart_host
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  uart_host_if.slave bus,
  output logic       posi,
  input  logic       piso
);
  state_t                state, state_nx;
  pkt_t                  new_pkt;
  logic [7:0]            req_addr_q;
  logic                  req_wr;
  logic [FRAME_BITS-1:0] tx_sh;
  logic [3:0]            tx_cnt;
  logic [4:0]            tx_bit;
  logic                  accept, bit_end, tx_last;
  logic                  rx_en, rx_start, rx_done, rx_stop_err;
  logic [PKT_W-1:0]      rx_data;
  logic                  tmo_hit;

  assign accept  = bus.req_valid && bus.req_ready;
  assign bit_end = tx_cnt == 4'(OVERSAMPLE - 1);
  assign tx_last = state == TX && bit_end && tx_bit == 5'(FRAME_BITS - 1);
  // shifter idles at all-ones, so posi is the line idle level outside TX
  assign posi    = tx_sh[0];

  always_comb begin
    new_pkt.wrb  = bus.req_write;
    new_pkt.addr = bus.req_addr;
    new_pkt.data = bus.req_write ? bus.req_wdata : 8'h00;
    new_pkt.par  = pkt_parity({bus.req_addr, new_pkt.data, bus.req_write});
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (accept) state_nx = TX;
      TX:       if (tx_last) state_nx = req_wr ? DONE : WAIT_RSP;
      WAIT_RSP: if (rx_done || tmo_hit) state_nx = DONE;
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    rx_en         = 1'b0;
    case (state)
      IDLE:     bus.req_ready = reset_n;
      WAIT_RSP: rx_en = 1'b1;
      DONE:     bus.rsp_valid = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_sh      <= '1;
      tx_cnt     <= '0;
      tx_bit     <= '0;
      req_addr_q <= '0;
      req_wr     <= 1'b0;
    end else if (accept) begin
      tx_sh      <= {1'b1, new_pkt, 1'b0};
      tx_cnt     <= '0;
      tx_bit     <= '0;
      req_addr_q <= bus.req_addr;
      req_wr     <= bus.req_write;
    end else if (state == TX) begin
      tx_cnt <= bit_end ? 4'd0 : tx_cnt + 4'd1;
      if (bit_end) begin
        tx_sh  <= {1'b1, tx_sh[FRAME_BITS-1:1]};
        tx_bit <= tx_bit + 5'd1;
      end
    end
  end

  // response fields are only rewritten on the way into DONE, so they hold
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus.rsp_write      <= 1'b0;
      bus.rsp_rdata      <= '0;
      bus.rsp_parity_err <= 1'b0;
      bus.rsp_addr_err   <= 1'b0;
      bus.rsp_timeout    <= 1'b0;
    end else if (tx_last && req_wr) begin
      bus.rsp_write      <= 1'b1;
      bus.rsp_rdata      <= '0;
      bus.rsp_parity_err <= 1'b0;
      bus.rsp_addr_err   <= 1'b0;
      bus.rsp_timeout    <= 1'b0;
    end else if (state == WAIT_RSP && rx_done) begin
      bus.rsp_write      <= 1'b0;
      bus.rsp_rdata      <= rx_data[DATA_LSB +: 8];
      bus.rsp_parity_err <= rx_stop_err ||
                            (rx_data[PAR_BIT] != pkt_parity(rx_data[PKT_W-2:0]));
      bus.rsp_addr_err   <= (rx_data[ADDR_LSB +: 8] != req_addr_q) || rx_data[WRB_BIT];
      bus.rsp_timeout    <= 1'b0;
    end else if (tmo_hit) begin
      bus.rsp_write      <= 1'b0;
      bus.rsp_rdata      <= '0;
      bus.rsp_parity_err <= 1'b0;
      bus.rsp_addr_err   <= 1'b0;
      bus.rsp_timeout    <= 1'b1;
    end
  end

`ifdef UART_HOST_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  logic [TMO_W-1:0] tmo_cnt;

  // restarting on a detected start gives a reply in flight its full window
  always_ff @(posedge clk) begin
    if (!reset_n || state != WAIT_RSP || rx_start) tmo_cnt <= '0;
    else                                           tmo_cnt <= tmo_cnt + TMO_W'(1);
  end
  assign tmo_hit = state == WAIT_RSP && !rx_done && tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1);
`else
  logic unused_rx_start;
  assign unused_rx_start = rx_start;
  assign tmo_hit         = 1'b0;
`endif

  uart_host_rx u_rx (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (rx_en),
    .piso     (piso),
    .start_det(rx_start),
    .done     (rx_done),
    .stop_err (rx_stop_err),
    .data     (rx_data)
  );
endmodule
